// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampled UART receiver (DBIT data bits LSB first, SB_TICK-tick stop bit).
// Optional macro UART_RX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_rx_os #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       s_tick,
    output logic [7:0] data_out,
    output logic       rx_done_tick,
    output logic       framing_err,
    output logic       parity_err,
    output logic       busy
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t            state_q;
    logic              rx_meta_q;
    logic              rx_s_q;
    logic [4:0]        tick_q;
    logic [4:0]        tick_d;
    logic [2:0]        bit_q;
    logic [DBIT-1:0]   shreg_q;
    logic [7:0]        data_out_q;
    logic              done_q;
    logic              ferr_q;

    assign tick_d = tick_q + 5'd1;

    // rx is asynchronous to clk; idle-high reset keeps a reset release from looking like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit_q;
    logic perr_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        tick_q  <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (tick_q == 5'd7) begin
                            // mid start bit: a high line here was only a glitch
                            if (!rx_s_q) begin
                                state_q <= DATA;
                                tick_q  <= '0;
                                bit_q   <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (tick_q == 5'd15) begin
                            tick_q  <= '0;
                            shreg_q <= {rx_s_q, shreg_q[DBIT-1:1]};
                            if (bit_q == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= PARITY;
`else
                                state_q <= STOP;
`endif
                            end else begin
                                bit_q <= bit_q + 3'd1;
                            end
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (tick_q == 5'd15) begin
                            tick_q    <= '0;
                            par_bit_q <= rx_s_q;
                            state_q   <= STOP;
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                end
`endif
                STOP: begin
                    if (s_tick) begin
                        if (tick_q == 5'(SB_TICK - 1)) begin
                            tick_q     <= '0;
                            done_q     <= 1'b1;
                            data_out_q <= 8'(shreg_q);
                            ferr_q     <= !rx_s_q;
`ifdef UART_RX_PARITY_EN
                            perr_q     <= par_bit_q ^ (^shreg_q);
`endif
                            // a low stop bit is delivered, then the line must go high again
                            state_q    <= rx_s_q ? IDLE : BREAK;
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out     = data_out_q;
    assign rx_done_tick = done_q;
    assign framing_err  = ferr_q;
    assign busy         = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: vector table of clean frames plus glitch, break, reset and parity sequences.
module tb_uart_rx_os;
    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       s_tick;
    logic [7:0] data_out;
    logic       rx_done_tick;
    logic       framing_err;
    logic       parity_err;
    logic       busy;

    uart_rx_os dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .data_out     (data_out),
        .rx_done_tick (rx_done_tick),
        .framing_err  (framing_err),
        .parity_err   (parity_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // s_tick every div clocks; div=1 holds it high continuously
    int div  = 4;
    int tcnt = 0;
    initial begin
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            tcnt   = (tcnt + 1 >= div) ? 0 : tcnt + 1;
            s_tick = (tcnt == 0);
        end
    end

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic       p;
    } rec_t;
    rec_t got[$];

    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) got.push_back('{data_out, framing_err, parity_err});
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_frame(input string name, input logic [7:0] d, input logic f, input logic p);
        rec_t r;
        check({name, " pulses"}, got.size(), 1);
        if (got.size() > 0) begin
            r = got.pop_front();
            check({name, " data"}, r.d, d);
            check({name, " framing_err"}, r.f, f);
            check({name, " parity_err"}, r.p, p);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (s_tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_bit(input logic v, input int n);
        rx = v;
        ticks(n);
    endtask

    // start bit, data bits LSB first, and the parity bit when the feature is built in
    task automatic send_data(input logic [7:0] d, input logic par_flip);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip, 16);
`endif
    endtask

    typedef struct {
        logic [7:0] data;
        int         dv;
        int         gap;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h55, 4, 4};
        vecs[1] = '{8'hA3, 4, 0};
        vecs[2] = '{8'h0F, 4, 4};
        vecs[3] = '{8'h00, 4, 4};
        vecs[4] = '{8'hFF, 4, 4};
        vecs[5] = '{8'h80, 1, 4};

        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset data_out", data_out, 8'h00);
        check("reset rx_done_tick", rx_done_tick, 1'b0);
        check("reset framing_err", framing_err, 1'b0);
        check("reset parity_err", parity_err, 1'b0);
        check("reset busy", busy, 1'b0);
        reset = 1'b0;
        ticks(10);

        for (int v = 0; v < 6; v++) begin
            div = vecs[v].dv;
            send_data(vecs[v].data, 1'b0);
            send_bit(1'b1, 16);
            check_frame($sformatf("vec%0d", v), vecs[v].data, 1'b0, 1'b0);
            if (vecs[v].gap > 0) begin
                ticks(vecs[v].gap);
                check($sformatf("vec%0d busy after", v), busy, 1'b0);
            end
        end
        div = 4;
        ticks(4);

        // short low glitch must be rejected at the mid-start sample
        rx = 1'b0;
        ticks(2);
        check("glitch busy during", busy, 1'b1);
        ticks(2);
        rx = 1'b1;
        ticks(5);
        check("glitch busy after", busy, 1'b0);
        ticks(20);
        check("glitch no pulse", got.size(), 0);

        // low stop bit, line held low: one delivery, then wait in break
        send_data(8'hC4, 1'b0);
        send_bit(1'b0, 40);
        check_frame("break", 8'hC4, 1'b1, 1'b0);
        check("break busy held", busy, 1'b1);
        rx = 1'b1;
        ticks(4);
        check("break busy released", busy, 1'b0);
        check("framing_err holds", framing_err, 1'b1);
        ticks(10);
        send_data(8'h12, 1'b0);
        send_bit(1'b1, 16);
        check_frame("after break", 8'h12, 1'b0, 1'b0);
        check("framing_err cleared", framing_err, 1'b0);
        ticks(4);

        // reset in the middle of data bit 3 of 0xFF
        send_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 16);
        rx = 1'b1;
        ticks(8);
        reset = 1'b1;
        #1;
        check("midreset data_out", data_out, 8'h00);
        check("midreset busy", busy, 1'b0);
        check("midreset rx_done_tick", rx_done_tick, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        ticks(200);
        check("midreset no pulse", got.size(), 0);
        send_data(8'h81, 1'b0);
        send_bit(1'b1, 16);
        check_frame("after reset", 8'h81, 1'b0, 1'b0);
        ticks(4);

`ifdef UART_RX_PARITY_EN
        send_data(8'h07, 1'b0);
        send_bit(1'b1, 16);
        check_frame("parity good", 8'h07, 1'b0, 1'b0);
        ticks(4);
        send_data(8'h07, 1'b1);
        send_bit(1'b1, 16);
        check_frame("parity bad", 8'h07, 1'b0, 1'b1);
        ticks(4);
        check("parity_err holds", parity_err, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- 16x-oversampled asynchronous serial receiver for the UART path.
- Recovers DBIT-bit frames (LSB first, 1 start bit, stop bit SB_TICK ticks long) from the serial line.
- Presents each received byte with a single-cycle valid pulse.
- Shares the baud-tick generator (s_tick, 16 per bit) with the transmit side; feeds the host-side command/FIFO logic.

Parameters:
- DBIT, 8, data bits per frame; legal range 5..8.
- SB_TICK, 16, s_tick count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2); legal range 1..32.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial line, idle high, asynchronous to clk.
- s_tick  in  1  one-clk pulse at 16x baud rate.
- data_out  out  8  received word; data in [DBIT-1:0], upper bits 0.
- rx_done_tick  out  1  one-clk pulse; data_out and error flags valid this cycle.
- framing_err  out  1  stop bit sampled low; valid with rx_done_tick.
- parity_err  out  1  parity mismatch; valid with rx_done_tick (see Optional Feature).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: data_out=0, rx_done_tick=0, framing_err=0, parity_err=0, busy=0, FSM=IDLE, counters=0, synchronizer flops=1. Reset mid-frame aborts; no rx_done_tick is produced.
- rx passes through a 2-flop synchronizer (rx_s). All FSM decisions use rx_s.
- Tick counter is 5 bits, bit counter is 3 bits. Counters advance only on cycles with s_tick=1.
- IDLE: when rx_s=0 → START, tick counter cleared.
- START: on each s_tick, increment. At count 7 (mid start bit):
  - if rx_s=0 → DATA, clear both counters;
  - if rx_s=1 → IDLE (glitch reject, no output).
- DATA: on each s_tick, increment. At count 15:
  - shift rx_s into the data shift register (LSB first) and clear the tick counter;
  - if bit counter = DBIT-1 → PARITY when the feature is enabled, else STOP;
  - otherwise increment the bit counter.
- STOP: on each s_tick, increment. At count SB_TICK-1, sample rx_s:
  - the same clock edge registers data_out and the flags; rx_done_tick=1 for exactly one clk;
  - rx_s=1 → IDLE, framing_err=0;
  - rx_s=0 → BREAK, framing_err=1 (the word is still delivered).
- BREAK: hold until rx_s=1, then → IDLE. No new frame can start while the line is held low.
- framing_err and parity_err hold their value until the next rx_done_tick.
- Timing: rx_done_tick asserts 2 synchronizer clks plus the s_tick-bounded sample point after the mid-stop sample. The interval between frame start and rx_done_tick is therefore 8+16*DBIT(+16)+SB_TICK s_ticks, within ±1 tick of edge alignment.
- s_tick held continuously high is legal (counts every clk).
- A frame start arriving in the cycle the FSM returns from STOP to IDLE is detected on the next clk.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - adds a PARITY state after DATA, with 16-tick timing identical to a data bit;
  - the sampled bit is compared against even parity (XOR of the DBIT data bits);
  - parity_err=1 on mismatch; the frame is always delivered.
- Undefined:
  - no PARITY state; the frame goes DATA → STOP;
  - parity_err is tied to 0.

Test Plan:
- Frame 0x55, 16 ticks/bit, SB_TICK=16 → one rx_done_tick, data_out=0x55, framing_err=0, busy falls the cycle after.
- Back-to-back frames 0xA3 then 0x0F with zero idle between stop and next start → two pulses, data_out 0xA3 then 0x0F, no frames lost.
- rx low pulse of 4 ticks then high → no rx_done_tick; FSM back in IDLE (busy=0) by tick 8.
- Frame 0xC4 with stop bit driven low, line held low 40 ticks then released → rx_done_tick with data_out=0xC4, framing_err=1; no second frame while low; the next frame 0x12 is received cleanly with framing_err=0.
- reset asserted during bit 3 of frame 0xFF → outputs return to reset values immediately; the following frame 0x81 is received correctly.
- With UART_RX_PARITY_EN: frame 0x07 with parity bit 1 → parity_err=0; same frame with parity bit 0 → parity_err=1. Without the macro, parity_err stays 0 for all frames.
